// File: rtl/polar_encode_engine.sv
`default_nettype none
// ============================================================================
// Module   : polar_encode_engine
// Brief    : Iterative polar encoder with run-time code length and frozen mask.
//            Optional macro POLAR_ENC_BITREV_EN: bit-reversed output ordering.
// Revision : 1.0 - initial release
// ============================================================================
module polar_encode_engine #(
    parameter int LOG_N_MAX = 11,
    parameter int K_MAX     = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [3:0]                            log_n,
    input  logic [(1<<LOG_N_MAX)-1:0]             frozen,
    input  logic [K_MAX-1:0]                      data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [(1<<LOG_N_MAX)-1:0]             encoded,
    output logic [$clog2((1<<LOG_N_MAX)+1)-1:0]   info_count,
    output logic                                  out_err
);

    localparam int              c_n_max   = 1 << LOG_N_MAX;
    localparam int              c_cw      = $clog2(c_n_max + 1);
    localparam int              c_kw      = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int              c_sw      = $clog2(LOG_N_MAX + 1);
    localparam logic [3:0]      c_log_max = 4'(LOG_N_MAX);
    localparam logic [c_cw-1:0] c_k_max   = c_cw'(K_MAX);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Positions whose index has bit s clear: the upper half of each butterfly pair.
    function automatic logic [c_n_max-1:0] f_mask(input int s);
        logic [c_n_max-1:0] m;
        m = '0;
        for (int j = 0; j < c_n_max; j++) begin
            if (((j >> s) & 1) == 0) m[j] = 1'b1;
        end
        return m;
    endfunction

    logic [1:0]         r_state;
    logic [c_sw-1:0]    r_stage;
    logic [c_sw-1:0]    r_stage_last;
    logic [3:0]         r_log_n;
    logic               r_log_bad;
    logic [c_n_max-1:0] r_x;
    logic [c_cw-1:0]    r_cnt;
    logic               r_err;

    logic               w_accept;
    logic               w_log_bad;
    logic               w_err;
    logic [c_n_max-1:0] w_u;
    logic [c_cw-1:0]    w_cnt;
    logic [c_n_max-1:0] w_bfly;
    logic [c_n_max-1:0] w_st [LOG_N_MAX];

    assign in_ready   = (r_state == c_st_idle) || ((r_state == c_st_done) && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (r_state == c_st_done);
    assign info_count = r_cnt;
    assign out_err    = r_err;

    assign w_log_bad = (log_n == 4'd0) || (log_n > c_log_max);
    assign w_err     = w_log_bad || (w_cnt > c_k_max);

    // Info-bit placement: each in-range free position takes the next data bit.
    always_comb begin
        w_u   = '0;
        w_cnt = '0;
        for (int i = 0; i < c_n_max; i++) begin
            if (((log_n >= c_log_max) || ((LOG_N_MAX'(i) >> log_n) == '0)) && !frozen[i]) begin
                if (!w_log_bad && (w_cnt < c_k_max)) w_u[i] = data[w_cnt[c_kw-1:0]];
                w_cnt = w_cnt + 1'b1;
            end
        end
    end

    for (genvar gs = 0; gs < LOG_N_MAX; gs++) begin : g_stage
        localparam logic [c_n_max-1:0] c_mask = f_mask(gs);
        assign w_st[gs] = r_x ^ ((r_x >> (1 << gs)) & c_mask);
    end

    always_comb begin
        w_bfly = r_x;
        for (int s = 0; s < LOG_N_MAX; s++) begin
            if (r_stage == c_sw'(s)) w_bfly = w_st[s];
        end
    end

`ifdef POLAR_ENC_BITREV_EN
    function automatic logic [LOG_N_MAX-1:0] f_bitrev(input logic [LOG_N_MAX-1:0] idx,
                                                      input logic [3:0] nb);
        logic [LOG_N_MAX-1:0] res;
        res = '0;
        for (int b = 0; b < LOG_N_MAX; b++) begin
            if (b < int'(nb)) res[int'(nb) - 1 - b] = idx[b];
        end
        return res;
    endfunction

    logic [c_n_max-1:0] w_enc;

    always_comb begin
        w_enc = '0;
        for (int i = 0; i < c_n_max; i++) begin
            if (!r_log_bad && ((LOG_N_MAX'(i) >> r_log_n) == '0))
                w_enc[f_bitrev(LOG_N_MAX'(i), r_log_n)] = r_x[i];
        end
    end

    assign encoded = w_enc;
`else
    assign encoded = r_x;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_stage      <= '0;
            r_stage_last <= '0;
            r_log_n      <= '0;
            r_log_bad    <= 1'b0;
            r_x          <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else if (w_accept) begin
            r_state      <= c_st_run;
            r_stage      <= '0;
            r_stage_last <= c_sw'(log_n - 4'd1);
            r_log_n      <= log_n;
            r_log_bad    <= w_log_bad;
            r_x          <= w_u;
            r_cnt        <= w_cnt;
            r_err        <= w_err;
        end else begin
            case (r_state)
                c_st_run: begin
                    r_x <= w_bfly;
                    // Bad-length words carry an all-zero word; they finish after one edge.
                    if (r_log_bad || (r_stage == r_stage_last)) r_state <= c_st_done;
                    else                                        r_stage <= r_stage + 1'b1;
                end
                c_st_done: begin
                    if (out_ready) r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_polar_encode_engine.sv
`default_nettype none
// Testbench for polar_encode_engine: generator-matrix reference model with a
// per-cycle output compare, directed corner words and randomized traffic.
module tb_polar_encode_engine;

    localparam int LOG = 11;
    localparam int N   = 1 << LOG;
    localparam int K   = 1024;
    localparam int CW  = $clog2(N + 1);

    typedef struct packed {
        logic [N-1:0] enc;
        logic [31:0]  cnt;
        logic         err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    log_n = '0;
    logic [N-1:0]  frozen = '0;
    logic [K-1:0]  data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  encoded;
    logic [CW-1:0] info_count;
    logic          out_err;

    exp_t          q[$];
    int            nvec = 0;
    int            nfail = 0;
    logic [N-1:0]  last_enc;
    int            last_cnt;
    int            last_err;

    polar_encode_engine #(.LOG_N_MAX(LOG), .K_MAX(K)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .log_n(log_n), .frozen(frozen), .data(data), .out_valid(out_valid),
        .out_ready(out_ready), .encoded(encoded), .info_count(info_count),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    function automatic int rev_bits(input int v, input int nb);
        int r;
        r = 0;
        for (int b = 0; b < nb; b++) if (((v >> b) & 1) != 0) r |= (1 << (nb - 1 - b));
        return r;
    endfunction

    // x = u * G_N with G_N[i][j] = 1 exactly when the bits of j are a subset of the bits of i.
    function automatic exp_t model(input logic [3:0] lg, input logic [N-1:0] fr,
                                   input logic [K-1:0] dt);
        exp_t e;
        logic [N-1:0] u;
        logic [N-1:0] x;
        int nact;
        int r;
        bit bad;
        bit b;
        bad  = (lg == 0) || (lg > LOG);
        nact = (lg > LOG) ? N : (1 << lg);
        u = '0;
        x = '0;
        r = 0;
        for (int i = 0; i < nact; i++) begin
            if (!fr[i]) begin
                if (!bad && r < K) u[i] = dt[r];
                r++;
            end
        end
        if (!bad) begin
            for (int j = 0; j < nact; j++) begin
                b = 1'b0;
                for (int i = j; i < nact; i = (i + 1) | j) b ^= u[i];
                x[j] = b;
            end
        end
        e.enc = '0;
`ifdef POLAR_ENC_BITREV_EN
        if (!bad) for (int j = 0; j < nact; j++) e.enc[rev_bits(j, int'(lg))] = x[j];
`else
        e.enc = x;
`endif
        e.cnt = r;
        e.err = bad || (r > K);
        return e;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_enc(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got low64=%h, expected low64=%h, %0d bits differ",
                     nm, act[63:0], exp[63:0], $countones(act ^ exp));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL unexpected_word: out_valid=1 with no word outstanding");
            end else begin
                chk_enc("encoded", encoded, q[0].enc);
                chk("info_count", longint'(info_count), longint'(q[0].cnt));
                chk("out_err", longint'(out_err), longint'(q[0].err));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_word(input logic [3:0] lg, input logic [N-1:0] fr, input logic [K-1:0] dt,
                           input int stall, output int acc_wait, output int lat);
        int exp_lat;
        log_n = lg; frozen = fr; data = dt; in_valid = 1'b1; out_ready = 1'b1;
        acc_wait = 0;
        lat = 0;
        @(negedge clk);
        while (!in_ready && acc_wait < 50) begin
            acc_wait++;
            @(negedge clk);
        end
        if (!in_ready) begin
            nvec++;
            nfail++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", acc_wait);
            in_valid = 1'b0;
            return;
        end
        q.push_back(model(lg, fr, dt));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = (stall == 0);
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        exp_lat = ((lg == 0) || (lg > LOG)) ? 1 : int'(lg);
        chk("latency", lat, exp_lat);
        last_enc = encoded;
        last_cnt = int'(info_count);
        last_err = int'(out_err);
        if (stall > 0) begin
            in_valid = 1'b1;
            log_n    = 4'($urandom);
            data     = ~dt;
            for (int c = 0; c < stall; c++) begin
                chk("held_in_ready", longint'(in_ready), 0);
                chk("held_out_valid", longint'(out_valid), 1);
                @(negedge clk);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic rand_word(output logic [3:0] lg, output logic [N-1:0] fr,
                             output logic [K-1:0] dt);
        int p;
        if ($urandom_range(0, 9) == 0) lg = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(12, 15));
        else                           lg = 4'($urandom_range(1, LOG));
        p = $urandom_range(0, 100);
        for (int i = 0; i < N; i++) fr[i] = ($urandom_range(0, 99) < p);
        for (int w = 0; w < K / 32; w++) dt[w*32 +: 32] = $urandom;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int aw;
        int lat;
        logic [3:0]   lg;
        logic [N-1:0] fr;
        logic [K-1:0] dt;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk_enc("reset_encoded", encoded, '0);
        chk("reset_info_count", longint'(info_count), 0);
        chk("reset_out_err", longint'(out_err), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three free bits frozen, one info bit at position 3.
        fr = '0; fr[2:0] = 3'b111; dt = '0; dt[0] = 1'b1;
        do_word(4'd2, fr, dt, 0, aw, lat);
        chk("t1_latency", lat, 2);
        chk("t1_encoded", longint'(last_enc[63:0]), 64'hF);
        chk("t1_info_count", last_cnt, 1);

        dt = '0; dt[1] = 1'b1;
        do_word(4'd1, '0, dt, 0, aw, lat);
        chk("t2a_encoded", longint'(last_enc[63:0]), 3);
        dt = '0; dt[0] = 1'b1;
        do_word(4'd1, '0, dt, 0, aw, lat);
        chk("t2b_encoded", longint'(last_enc[63:0]), 1);

        for (int w = 0; w < K / 32; w++) dt[w*32 +: 32] = $urandom;
        do_word(4'd3, '1, dt, 0, aw, lat);
        chk("t3_all_frozen_enc", longint'(last_enc[63:0]), 0);
        chk("t3_all_frozen_cnt", last_cnt, 0);
        chk("t3_all_frozen_err", last_err, 0);
        do_word(4'd0, '0, dt, 0, aw, lat);
        chk("t3_log0_latency", lat, 1);
        chk("t3_log0_err", last_err, 1);
        chk("t3_log0_enc", longint'(last_enc[63:0]), 0);
        do_word(4'd12, '0, dt, 0, aw, lat);
        chk("t3_log12_err", last_err, 1);
        do_word(4'd11, '0, dt, 0, aw, lat);
        chk("kmax_overflow_err", last_err, 1);
        chk("kmax_overflow_cnt", last_cnt, N);

        // Held output under backpressure, then a back-to-back accept.
        rand_word(lg, fr, dt);
        do_word(4'd3, fr, dt, 5, aw, lat);
        rand_word(lg, fr, dt);
        do_word(4'd4, fr, dt, 0, aw, lat);
        chk("b2b_no_bubble", aw, 0);

        // Reset while a word is mid-flight.
        rand_word(lg, fr, dt);
        log_n = 4'd6; frozen = fr; data = dt; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_in_ready", longint'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("postrst_out_valid", longint'(out_valid), 0);
        rand_word(lg, fr, dt);
        do_word(4'd5, fr, dt, 0, aw, lat);

        for (int n = 0; n < 60; n++) begin
            rand_word(lg, fr, dt);
            do_word(lg, fr, dt, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, aw, lat);
        end

        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
